// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode handshake bundle: upstream pair input, decoder window output.
// Ports (slave = queue side):
//   flush, fb_valid, fb_*1/fb_*2, dec_accept  -> into the queue
//   get_data_req, dec_valid, dec_*1/dec_*2, occupancy <- out of the queue
interface fetch_decode_queue_if;
    logic        flush;
    logic        get_data_req;
    logic        fb_valid;
    logic [31:0] fb_pc1;
    logic [31:0] fb_pc2;
    logic [31:0] fb_inst1;
    logic [31:0] fb_inst2;
    logic [31:0] fb_pre_branch_addr1;
    logic [31:0] fb_pre_branch_addr2;
    logic        fb_is_exception1;
    logic        fb_is_exception2;
    logic [6:0]  fb_exception_cause1;
    logic [6:0]  fb_exception_cause2;
    logic [1:0]  dec_valid;
    logic [31:0] dec_pc1;
    logic [31:0] dec_pc2;
    logic [31:0] dec_inst1;
    logic [31:0] dec_inst2;
    logic [31:0] dec_pred1;
    logic [31:0] dec_pred2;
    logic        dec_exc1;
    logic        dec_exc2;
    logic [6:0]  dec_cause1;
    logic [6:0]  dec_cause2;
    logic [1:0]  dec_accept;
    logic [2:0]  occupancy;

    modport master (
        output flush, fb_valid, fb_pc1, fb_pc2, fb_inst1, fb_inst2,
               fb_pre_branch_addr1, fb_pre_branch_addr2,
               fb_is_exception1, fb_is_exception2,
               fb_exception_cause1, fb_exception_cause2, dec_accept,
        input  get_data_req, dec_valid, dec_pc1, dec_pc2, dec_inst1, dec_inst2,
               dec_pred1, dec_pred2, dec_exc1, dec_exc2, dec_cause1, dec_cause2,
               occupancy
    );

    modport slave (
        input  flush, fb_valid, fb_pc1, fb_pc2, fb_inst1, fb_inst2,
               fb_pre_branch_addr1, fb_pre_branch_addr2,
               fb_is_exception1, fb_is_exception2,
               fb_exception_cause1, fb_exception_cause2, dec_accept,
        output get_data_req, dec_valid, dec_pc1, dec_pc2, dec_inst1, dec_inst2,
               dec_pred1, dec_pred2, dec_exc1, dec_exc2, dec_cause1, dec_cause2,
               occupancy
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Four-entry circular instruction queue between the fetch buffer and decode.
// Accepts an instruction pair per push, presents the two oldest entries to decode.
// Ports:
//   cpu_clk  clock
//   cpu_rst  synchronous active-high reset (clears pointers/count only)
//   bus      fetch_decode_queue_if.slave: fetch pair in, decode window out
module fetch_decode_queue (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    fetch_decode_queue_if.slave   bus
);
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CAUSE_W = 7;
    localparam int unsigned ENT_W   = 2 * XLEN + XLEN + 1 + CAUSE_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             req_c;
    logic             push_c;
    logic [1:0]       valid_c;
    logic [1:0]       pops_c;
    logic [PTR_W-1:0] head_p1_c;
    logic [PTR_W-1:0] tail_p1_c;
    logic [ENT_W-1:0] wr1_c, wr2_c;
    logic [ENT_W-1:0] rd1_c, rd2_c;

    // Request, pop count and next-state pointers; flush/reset win over push and pop.
    always_comb begin
        req_c     = !bus.flush && !cpu_rst && (count_q <= CNT_W'(2));
        push_c    = req_c && bus.fb_valid;
        valid_c   = {count_q >= CNT_W'(2), count_q >= CNT_W'(1)};
        head_p1_c = head_q + PTR_W'(1);
        tail_p1_c = tail_q + PTR_W'(1);

        // Second accept only counts together with the first (2'b10 pops nothing).
        pops_c = 2'd0;
        if (bus.dec_accept[0] && valid_c[0]) begin
            pops_c = (bus.dec_accept[1] && valid_c[1]) ? 2'd2 : 2'd1;
        end

        head_d  = head_q + PTR_W'(pops_c);
        tail_d  = push_c ? tail_q + PTR_W'(2) : tail_q;
        count_d = count_q + (push_c ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(pops_c);

        if (cpu_rst || bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Entry layout: pred | pc | inst | exc | cause.
    always_comb begin
        wr1_c = {bus.fb_pre_branch_addr1, bus.fb_pc1, bus.fb_inst1,
                 bus.fb_is_exception1, bus.fb_exception_cause1};
        wr2_c = {bus.fb_pre_branch_addr2, bus.fb_pc2, bus.fb_inst2,
                 bus.fb_is_exception2, bus.fb_exception_cause2};
        rd1_c = mem_q[head_q];
        rd2_c = mem_q[head_p1_c];
    end

    // Pointer/count state.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is intentionally not cleared by reset or flush.
    always_ff @(posedge cpu_clk) begin
        if (push_c) begin
            mem_q[tail_q]    <= wr1_c;
            mem_q[tail_p1_c] <= wr2_c;
        end
    end

    // Decode window is read straight from storage.
    always_comb begin
        bus.get_data_req = req_c;
        bus.dec_valid    = valid_c;
        bus.occupancy    = count_q;
        {bus.dec_pred1, bus.dec_pc1, bus.dec_inst1, bus.dec_exc1, bus.dec_cause1} = rd1_c;
        {bus.dec_pred2, bus.dec_pc2, bus.dec_inst2, bus.dec_exc2, bus.dec_cause2} = rd2_c;
    end
endmodule
